// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle ALU with an integrated RV32M multiply/divide unit.
// Base ops complete in one cycle. Multiply runs a shift-add loop over
// XLEN cycles. Divide runs a restoring loop over XLEN cycles.
// Define ALU_MDU_DIV_EN to compile in the divider. When it is not defined,
// the div/divu/rem/remu encodings decode as illegal.
module alu_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SHW = $clog2(XLEN);
`ifdef ALU_MDU_DIV_EN
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_MDU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CL_SINGLE = 2'd0,
        CL_MUL    = 2'd1,
        CL_DIV    = 2'd2,
        CL_ILL    = 2'd3
    } op_class_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;
    logic                zero_q;
    logic                illegal_q;
    logic [SHW-1:0]      cnt_q;
    // Multiply: {partial product high, multiplier low}.
    // Divide: {partial remainder high, dividend/quotient low}.
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mcand_q;   // multiplicand magnitude or divisor magnitude
    logic                neg_q;     // negate product / quotient
    logic                hi_q;      // select high half (mulh*, rem*)
`ifdef ALU_MDU_DIV_EN
    logic                negr_q;    // negate remainder
`endif

    op_class_e           cls;
    logic [XLEN-1:0]     single_res;
    logic [SHW-1:0]      shamt;
    logic                sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_acc;
    logic [2*XLEN-1:0]   mul_prod;
    logic [XLEN-1:0]     mul_res;
`ifdef ALU_MDU_DIV_EN
    logic [XLEN:0]       div_sh;
    logic [XLEN:0]       div_diff;
    logic                div_qbit;
    logic [XLEN-1:0]     div_rem;
    logic [2*XLEN-1:0]   div_acc;
    logic [XLEN-1:0]     div_res;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;
    assign shamt   = b[SHW-1:0];

    // Decode the op class and compute every single-cycle result, including divide special cases.
    always_comb begin
        cls        = CL_SINGLE;
        single_res = '0;
        case (alu_op)
            2'b00: single_res = a + b;
            2'b01: single_res = a - b;
            2'b10: begin
                if (!funct7_0) begin
                    case ({funct7_5, funct3})
                        4'b0000: single_res = a + b;
                        4'b1000: single_res = a - b;
                        4'b0111: single_res = a & b;
                        4'b0110: single_res = a | b;
                        4'b0100: single_res = a ^ b;
                        4'b0010: single_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                        4'b0011: single_res = {{(XLEN-1){1'b0}}, (a < b)};
                        4'b0001: single_res = a << shamt;
                        4'b0101: single_res = a >> shamt;
                        4'b1101: single_res = $unsigned($signed(a) >>> shamt);
                        default: cls = CL_ILL;
                    endcase
                end else if (funct7_5) begin
                    cls = CL_ILL;
                end else if (!funct3[2]) begin
                    cls = CL_MUL;
                end else begin
`ifdef ALU_MDU_DIV_EN
                    // funct3[1] selects remainder, funct3[0] selects unsigned.
                    if (b == '0) begin
                        single_res = funct3[1] ? a : '1;
                    end else if (!funct3[0] && (a == SMIN) && (b == '1)) begin
                        single_res = funct3[1] ? '0 : a;
                    end else begin
                        cls = CL_DIV;
                    end
`else
                    cls = CL_ILL;
`endif
                end
            end
            default: cls = CL_ILL;
        endcase
    end

    // Operand sign handling and magnitude conversion for the iterative units.
    always_comb begin
        if (funct3[2]) begin
            sgn_a = ~funct3[0];
            sgn_b = ~funct3[0];
        end else begin
            sgn_a = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
            sgn_b = (funct3[1:0] == 2'b01);
        end
        neg_a = sgn_a & a[XLEN-1];
        neg_b = sgn_b & b[XLEN-1];
        mag_a = neg_a ? ('0 - a) : a;
        mag_b = neg_b ? ('0 - b) : b;
    end

    // One shift-add multiply step and the signed, half-selected product of that step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
        mul_prod = neg_q ? ('0 - mul_acc) : mul_acc;
        mul_res  = hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
    end

`ifdef ALU_MDU_DIV_EN
    // One restoring divide step and the signed quotient or remainder of that step.
    always_comb begin
        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_sh - {1'b0, mcand_q};
        div_qbit = ~div_diff[XLEN];
        div_rem  = div_qbit ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        div_acc  = {div_rem, acc_q[XLEN-2:0], div_qbit};
        if (hi_q) begin
            div_res = negr_q ? ('0 - div_rem) : div_rem;
        end else begin
            div_res = neg_q ? ('0 - div_acc[XLEN-1:0]) : div_acc[XLEN-1:0];
        end
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            hi_q      <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            negr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    state_q   <= S_IDLE;
                    if (start) begin
                        case (cls)
                            CL_MUL: begin
                                state_q <= S_MUL;
                                busy_q  <= 1'b1;
                                cnt_q   <= SHW'(XLEN-1);
                                acc_q   <= {{XLEN{1'b0}}, mag_b};
                                mcand_q <= mag_a;
                                neg_q   <= neg_a ^ neg_b;
                                hi_q    <= (funct3[1:0] != 2'b00);
                            end
`ifdef ALU_MDU_DIV_EN
                            CL_DIV: begin
                                state_q <= S_DIV;
                                busy_q  <= 1'b1;
                                cnt_q   <= SHW'(XLEN-1);
                                acc_q   <= {{XLEN{1'b0}}, mag_a};
                                mcand_q <= mag_b;
                                neg_q   <= neg_a ^ neg_b;
                                negr_q  <= neg_a;
                                hi_q    <= funct3[1];
                            end
`endif
                            CL_ILL: begin
                                state_q   <= S_DONE;
                                done_q    <= 1'b1;
                                illegal_q <= 1'b1;
                                result_q  <= '0;
                                zero_q    <= 1'b1;
                            end
                            default: begin
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                                result_q <= single_res;
                                zero_q   <= (single_res == '0);
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc;
                    if (cnt_q == '0) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= mul_res;
                        zero_q   <= (mul_res == '0);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef ALU_MDU_DIV_EN
                S_DIV: begin
                    acc_q <= div_acc;
                    if (cnt_q == '0) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= div_res;
                        zero_q   <= (div_res == '0);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed-vector bench for alu_mdu (XLEN=32).
module tb_alu_mdu;
    logic        clk, reset, start;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5, funct7_0;
    logic [31:0] a, b;
    logic        busy, done, zero, illegal;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
        .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .zero(zero), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one op and wait (bounded) for done. lat=1 means done in the cycle after E0.
    task automatic run_op(input logic [1:0] op, input logic [3:0] f53, input logic f0,
                          input logic [31:0] aa, input logic [31:0] bb,
                          output int lat, output int bcnt, output logic ovl);
        alu_op = op; funct7_5 = f53[3]; funct3 = f53[2:0]; funct7_0 = f0;
        a = aa; b = bb; start = 1'b1;
        lat = 0; bcnt = 0; ovl = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                a = ~aa;
                b = ~bb;
            end
            if (busy) bcnt++;
            if (busy && done) ovl = 1'b1;
        end while (!done && lat < 100);
    endtask

    task automatic test_reset;
        start = 0; alu_op = 0; funct3 = 0; funct7_5 = 0; funct7_0 = 0; a = 0; b = 0;
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset.busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset.done got=%b exp=0", done); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset.result got=%h exp=0", result); end
        vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset.zero got=%b exp=1", zero); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset.illegal got=%b exp=0", illegal); end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset.idle got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_add;
        int lat, bcnt; logic ovl;
        run_op(2'b00, 4'b0000, 1'b0, 32'd5, 32'd7, lat, bcnt, ovl);
        vectors++; if (result !== 32'd12) begin miscompares++; $display("FAIL add.result got=%h exp=%h", result, 32'd12); end
        vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL add.zero got=%b exp=0", zero); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL add.latency got=%0d exp=1", lat); end
        vectors++; if (bcnt !== 0) begin miscompares++; $display("FAIL add.busy got=%0d exp=0", bcnt); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL add.illegal got=%b exp=0", illegal); end
        run_op(2'b01, 4'b0000, 1'b0, 32'd7, 32'd7, lat, bcnt, ovl);
        vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL sub.result got=%h exp=0", result); end
        vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL sub.zero got=%b exp=1", zero); end
    endtask

    task automatic test_decode;
        logic [3:0]  f  [12];
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic [31:0] ve [12];
        int lat, bcnt; logic ovl;
        f  = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0010,
               4'b0011, 4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};
        va = '{32'h10, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF,
               32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
        vb = '{32'h20, 32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h1,
               32'h1, 32'h24, 32'h4, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ve = '{32'h30, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h1,
               32'h0, 32'h10, 32'h08000000, 32'hF8000000, 32'h0, 32'h1};
        for (int i = 0; i < 12; i++) begin
            run_op(2'b10, f[i], 1'b0, va[i], vb[i], lat, bcnt, ovl);
            vectors++;
            if (result !== ve[i] || lat !== 1 || illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL decode[%0d] f=%b got=%h lat=%0d ill=%b exp=%h lat=1 ill=0", i, f[i], result, lat, illegal, ve[i]);
            end
        end
    endtask

    task automatic test_illegal;
        int lat, bcnt; logic ovl;
        logic [1:0] ops [3];
        logic [3:0] fs  [3];
        logic       f0s [3];
        ops = '{2'b11, 2'b10, 2'b10};
        fs  = '{4'b0000, 4'b1001, 4'b1000};
        f0s = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(2'b00, 4'b0000, 1'b0, 32'd1, 32'd2, lat, bcnt, ovl);
            run_op(ops[i], fs[i], f0s[i], 32'd9, 32'd3, lat, bcnt, ovl);
            vectors++;
            if (illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || lat !== 1) begin
                miscompares++;
                $display("FAIL illegal[%0d] got ill=%b res=%h zero=%b lat=%0d exp ill=1 res=0 zero=1 lat=1", i, illegal, result, zero, lat);
            end
        end
    endtask

    task automatic test_mul;
        logic [2:0]  f  [6];
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] ve [6];
        logic        vz [6];
        int lat, bcnt; logic ovl;
        f  = '{3'b001, 3'b000, 3'b001, 3'b010, 3'b011, 3'b000};
        va = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00010000};
        vb = '{32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00010000};
        ve = '{32'hFFFFFFFF, 32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0};
        vz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(2'b10, {1'b0, f[i]}, 1'b1, va[i], vb[i], lat, bcnt, ovl);
            vectors++;
            if (result !== ve[i] || zero !== vz[i] || illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL mul[%0d] got=%h zero=%b ill=%b exp=%h zero=%b ill=0", i, result, zero, illegal, ve[i], vz[i]);
            end
            vectors++;
            if (lat !== 33 || bcnt !== 32 || ovl !== 1'b0) begin
                miscompares++;
                $display("FAIL mul_timing[%0d] got lat=%0d busy=%0d ovl=%b exp lat=33 busy=32 ovl=0", i, lat, bcnt, ovl);
            end
        end
    endtask

`ifdef ALU_MDU_DIV_EN
    task automatic test_div;
        logic [2:0]  f  [10];
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] ve [10];
        int          vl [10];
        int lat, bcnt; logic ovl;
        f  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        va = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd9, 32'd9,
               32'h80000000, 32'h80000000, 32'd7, 32'd7};
        vb = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
        ve = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd9,
               32'h80000000, 32'h0, 32'hFFFFFFFD, 32'd1};
        vl = '{33, 33, 33, 33, 1, 1, 1, 1, 33, 33};
        for (int i = 0; i < 10; i++) begin
            run_op(2'b10, {1'b0, f[i]}, 1'b1, va[i], vb[i], lat, bcnt, ovl);
            vectors++;
            if (result !== ve[i] || lat !== vl[i] || illegal !== 1'b0 || ovl !== 1'b0) begin
                miscompares++;
                $display("FAIL div[%0d] got=%h lat=%0d ill=%b ovl=%b exp=%h lat=%0d ill=0 ovl=0", i, result, lat, illegal, ovl, ve[i], vl[i]);
            end
        end
    endtask
`else
    task automatic test_no_div;
        int lat, bcnt; logic ovl;
        run_op(2'b00, 4'b0000, 1'b0, 32'd4, 32'd4, lat, bcnt, ovl);
        run_op(2'b10, 4'b0110, 1'b1, 32'd9, 32'd2, lat, bcnt, ovl);
        vectors++;
        if (illegal !== 1'b1 || result !== 32'h0 || lat !== 1 || bcnt !== 0) begin
            miscompares++;
            $display("FAIL rem_nodiv got ill=%b res=%h lat=%0d busy=%0d exp ill=1 res=0 lat=1 busy=0", illegal, result, lat, bcnt);
        end
        run_op(2'b10, 4'b0100, 1'b1, 32'd100, 32'd7, lat, bcnt, ovl);
        vectors++;
        if (illegal !== 1'b1 || result !== 32'h0 || lat !== 1) begin
            miscompares++;
            $display("FAIL div_nodiv got ill=%b res=%h lat=%0d exp ill=1 res=0 lat=1", illegal, result, lat);
        end
    endtask
`endif

    task automatic test_busy_ignore;
        int lat;
        alu_op = 2'b10; funct7_5 = 1'b0; funct7_0 = 1'b1; funct3 = 3'b000;
        a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (lat == 10) begin alu_op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1; end
            if (lat == 11) start = 1'b0;
        end while (!done && lat < 100);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL busy_ignore.latency got=%0d exp=33", lat); end
        vectors++; if (result !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL busy_ignore.result got=%h exp=FFFFFFEB", result); end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFFFFEB) begin
            miscompares++;
            $display("FAIL busy_ignore.noqueue got busy=%b done=%b res=%h exp 0 0 FFFFFFEB", busy, done, result);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt; logic ovl;
        run_op(2'b00, 4'b0000, 1'b0, 32'd5, 32'd7, lat, bcnt, ovl);
        run_op(2'b01, 4'b0000, 1'b0, 32'd30, 32'd8, lat, bcnt, ovl);
        vectors++;
        if (result !== 32'd22 || lat !== 1) begin
            miscompares++;
            $display("FAIL b2b.single got=%h lat=%0d exp=16 lat=1", result, lat);
        end
        run_op(2'b10, 4'b0000, 1'b1, 32'hFFFFFFFD, 32'd7, lat, bcnt, ovl);
        run_op(2'b00, 4'b0000, 1'b0, 32'd1, 32'd2, lat, bcnt, ovl);
        vectors++;
        if (result !== 32'd3 || lat !== 1) begin
            miscompares++;
            $display("FAIL b2b.after_mul got=%h lat=%0d exp=3 lat=1", result, lat);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || result !== 32'd3) begin
            miscompares++;
            $display("FAIL b2b.hold got done=%b res=%h exp done=0 res=3", done, result);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt; logic ovl;
        logic saw_done;
        alu_op = 2'b10; funct7_5 = 1'b0; funct7_0 = 1'b1; funct3 = 3'b000;
        a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        lat = 0; saw_done = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (done) saw_done = 1'b1;
        end while (lat < 16);
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid.async got busy=%b done=%b res=%h zero=%b exp 0 0 0 1", busy, done, result, zero);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL reset_mid.no_done got=%b exp=0", saw_done); end
        run_op(2'b00, 4'b0000, 1'b0, 32'd2, 32'd2, lat, bcnt, ovl);
        vectors++;
        if (result !== 32'd4 || lat !== 1) begin
            miscompares++;
            $display("FAIL reset_mid.recover got=%h lat=%0d exp=4 lat=1", result, lat);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_decode;
        test_illegal;
        test_mul;
`ifdef ALU_MDU_DIV_EN
        test_div;
`else
        test_no_div;
`endif
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
